// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings, state type and defaults for the pipeline hazard controller.
`default_nettype none

package pipe_ctrl_pkg;

  localparam logic [1:0] PC_SEQ  = 2'd0;
  localparam logic [1:0] PC_TGT  = 2'd1;
  localparam logic [1:0] PC_TRAP = 2'd2;

  localparam int DEF_REDIRECT_BUBBLES  = 1;
  localparam int DEF_INIT_FLUSH_CYCLES = 2;
  localparam int DEF_CNT_W             = 16;

  typedef enum logic [1:0] {
    S_INIT     = 2'd0,
    S_RUN      = 2'd1,
    S_REDIRECT = 2'd2
  } state_t;

  // Width needed to hold values 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
`default_nettype none

module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush/PC-select controller for the 5-stage RV32I pipeline,
// with redirect-bubble sequencing, post-reset purge and saturating counters.
`default_nettype none

module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REDIRECT_BUBBLES  = DEF_REDIRECT_BUBBLES,
  parameter int INIT_FLUSH_CYCLES = DEF_INIT_FLUSH_CYCLES,
  parameter int CNT_W             = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_branch_taken,
  input  logic             ex_jump,
  input  logic             id_load_use,
  input  logic             if_busy,
  input  logic             mem_busy,
  input  logic             trap_req,
  output logic             stall_pc,
  output logic             stall_if_id,
  output logic             stall_id_ex,
  output logic             stall_ex_mem,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             flush_ex_mem,
  output logic             flush_mem_wb,
  output logic [1:0]       pc_sel,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int RW = cnt_width(REDIRECT_BUBBLES);
  localparam int IW = cnt_width(INIT_FLUSH_CYCLES);
  localparam logic [RW-1:0] RD_LOAD   = RW'(REDIRECT_BUBBLES - 1);
  localparam logic [IW-1:0] INIT_LOAD = IW'(INIT_FLUSH_CYCLES - 1);
  localparam bit MULTI_BUBBLE = (REDIRECT_BUBBLES > 1);

  state_t          state, state_nx;
  logic [IW-1:0]   init_cnt, init_cnt_nx;
  logic [RW-1:0]   rd_cnt, rd_cnt_nx;

  logic s_pc, s_ifid, s_idex, s_exmem;
  logic f_ifid, f_idex, f_exmem, f_memwb;
  logic redirect_go;
  logic in_redirect;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_INIT;
      init_cnt <= INIT_LOAD;
      rd_cnt   <= '0;
    end else begin
      state    <= state_nx;
      init_cnt <= init_cnt_nx;
      rd_cnt   <= rd_cnt_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    init_cnt_nx = init_cnt;
    rd_cnt_nx   = rd_cnt;
    s_pc        = 1'b0;
    s_ifid      = 1'b0;
    s_idex      = 1'b0;
    s_exmem     = 1'b0;
    f_ifid      = 1'b0;
    f_idex      = 1'b0;
    f_exmem     = 1'b0;
    f_memwb     = 1'b0;
    pc_sel      = PC_SEQ;
    redirect_go = 1'b0;
    in_redirect = (state == S_REDIRECT);

    if (rst || (state == S_INIT)) begin
      s_pc    = 1'b1;
      f_ifid  = 1'b1;
      f_idex  = 1'b1;
      f_exmem = 1'b1;
      f_memwb = 1'b1;
      if (init_cnt == '0) begin
        state_nx = S_RUN;
      end else begin
        init_cnt_nx = init_cnt - IW'(1);
      end
    end else if (mem_busy) begin
      // EX is frozen, so any pending redirect stays asserted and is taken later;
      // the redirect bubble count is held.
      s_pc    = 1'b1;
      s_ifid  = 1'b1;
      s_idex  = 1'b1;
      s_exmem = 1'b1;
      f_memwb = 1'b1;
      f_ifid  = in_redirect;
    end else if (trap_req) begin
      f_ifid      = 1'b1;
      f_idex      = 1'b1;
      f_exmem     = 1'b1;
      pc_sel      = PC_TRAP;
      redirect_go = 1'b1;
    end else if (ex_branch_taken || ex_jump) begin
      f_ifid      = 1'b1;
      f_idex      = 1'b1;
      pc_sel      = PC_TGT;
      redirect_go = 1'b1;
    end else if (in_redirect) begin
      f_ifid    = 1'b1;
      s_pc      = if_busy;
      rd_cnt_nx = rd_cnt - RW'(1);
      if (rd_cnt == RW'(1)) begin
        state_nx = S_RUN;
      end
    end else if (id_load_use) begin
      s_pc   = 1'b1;
      s_ifid = 1'b1;
      f_idex = 1'b1;
    end else if (if_busy) begin
      s_pc   = 1'b1;
      f_ifid = 1'b1;
    end

    if (redirect_go) begin
      if (MULTI_BUBBLE) begin
        state_nx  = S_REDIRECT;
        rd_cnt_nx = RD_LOAD;
      end else begin
        state_nx = S_RUN;
      end
    end
  end

  // A register that is being cleared must not also be held.
  assign stall_pc     = s_pc;
  assign stall_if_id  = s_ifid  & ~f_ifid;
  assign stall_id_ex  = s_idex  & ~f_idex;
  assign stall_ex_mem = s_exmem & ~f_exmem;
  assign flush_if_id  = f_ifid;
  assign flush_id_ex  = f_idex;
  assign flush_ex_mem = f_exmem;
  assign flush_mem_wb = f_memwb;

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (pc_sel != PC_SEQ),
    .count (flush_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_pc && (state != S_INIT)),
    .count (stall_cnt)
  );

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench: directed vector table plus randomized run against a behavioural model.
`default_nettype none

module tb_pipe_hazard_ctrl;

  logic clk, rst;
  logic br, jmp, lu, ifb, memb, trap;
  logic [9:0]  oa, ob;
  logic [3:0]  fca, sca;
  logic [15:0] fcb, scb;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state per instance: 0 = (RB=2, INIT=2, CNT_W=4), 1 = (RB=3, INIT=3, CNT_W=16)
  int rb[2]   = '{2, 3};
  int ini[2]  = '{2, 3};
  int maxc[2] = '{15, 65535};
  int init_left[2], bub[2], fc[2], sc[2];

  localparam logic [9:0] INIT_O = 10'b1000111100;

  pipe_hazard_ctrl #(.REDIRECT_BUBBLES(2), .INIT_FLUSH_CYCLES(2), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst), .ex_branch_taken(br), .ex_jump(jmp), .id_load_use(lu),
    .if_busy(ifb), .mem_busy(memb), .trap_req(trap),
    .stall_pc(oa[9]), .stall_if_id(oa[8]), .stall_id_ex(oa[7]), .stall_ex_mem(oa[6]),
    .flush_if_id(oa[5]), .flush_id_ex(oa[4]), .flush_ex_mem(oa[3]), .flush_mem_wb(oa[2]),
    .pc_sel(oa[1:0]), .flush_cnt(fca), .stall_cnt(sca)
  );

  pipe_hazard_ctrl #(.REDIRECT_BUBBLES(3), .INIT_FLUSH_CYCLES(3), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .ex_branch_taken(br), .ex_jump(jmp), .id_load_use(lu),
    .if_busy(ifb), .mem_busy(memb), .trap_req(trap),
    .stall_pc(ob[9]), .stall_if_id(ob[8]), .stall_id_ex(ob[7]), .stall_ex_mem(ob[6]),
    .flush_if_id(ob[5]), .flush_id_ex(ob[4]), .flush_ex_mem(ob[3]), .flush_mem_wb(ob[2]),
    .pc_sel(ob[1:0]), .flush_cnt(fcb), .stall_cnt(scb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          r;
    bit [5:0]    in;   // {br, jmp, lu, ifb, memb, trap}
    logic [9:0]  exp_o;
    int          exp_fc;
    int          exp_sc;
    string       name;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, bit [5:0] in, logic [9:0] o, int f, int s, string n);
    vec_t v;
    v.r = r; v.in = in; v.exp_o = o; v.exp_fc = f; v.exp_sc = s; v.name = n;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Behavioural reference: returns the outputs for this cycle and advances the model.
  function automatic logic [9:0] model_step(input int k, input bit r, input bit [5:0] in);
    bit sp = 0, sif = 0, sie = 0, sem = 0, fif = 0, fie = 0, fem = 0, fmw = 0;
    bit [1:0] pc = 2'd0;
    bit redir;
    if (r) begin
      init_left[k] = ini[k]; bub[k] = 0; fc[k] = 0; sc[k] = 0;
      return INIT_O;
    end
    if (init_left[k] > 0) begin
      init_left[k]--;
      return INIT_O;
    end
    redir = (bub[k] > 0);
    if (in[1]) begin
      sp = 1; sie = 1; sem = 1; fmw = 1;
      if (redir) fif = 1; else sif = 1;
    end else if (in[0]) begin
      fif = 1; fie = 1; fem = 1; pc = 2'd2; bub[k] = rb[k] - 1;
    end else if (in[5] | in[4]) begin
      fif = 1; fie = 1; pc = 2'd1; bub[k] = rb[k] - 1;
    end else if (redir) begin
      fif = 1; sp = in[2]; bub[k]--;
    end else if (in[3]) begin
      sp = 1; sif = 1; fie = 1;
    end else if (in[2]) begin
      sp = 1; fif = 1;
    end
    if (pc != 2'd0 && fc[k] < maxc[k]) fc[k]++;
    if (sp && sc[k] < maxc[k]) sc[k]++;
    return {sp, sif, sie, sem, fif, fie, fem, fmw, pc};
  endfunction

  task automatic drive(input bit r, input bit [5:0] in);
    rst = r;
    {br, jmp, lu, ifb, memb, trap} = in;
    #2;
  endtask

  task automatic model_checks(input bit r, input bit [5:0] in);
    logic [9:0] e;
    for (int k = 0; k < 2; k++) begin
      logic [9:0]  o  = (k == 0) ? oa : ob;
      logic [31:0] af = (k == 0) ? 32'(fca) : 32'(fcb);
      logic [31:0] as = (k == 0) ? 32'(sca) : 32'(scb);
      chk($sformatf("m%0d_flush_cnt", k), af, 32'(fc[k]));
      chk($sformatf("m%0d_stall_cnt", k), as, 32'(sc[k]));
      e = model_step(k, r, in);
      chk($sformatf("m%0d_outputs", k), 32'(o), 32'(e));
      chk($sformatf("m%0d_stall_flush_overlap", k),
          32'((o[8] & o[5]) | (o[7] & o[4]) | (o[6] & o[3])), 32'd0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    {br, jmp, lu, ifb, memb, trap} = 6'b0;
    for (int k = 0; k < 2; k++) begin
      init_left[k] = ini[k]; bub[k] = 0; fc[k] = 0; sc[k] = 0;
    end
    tick();

    tbl.push_back(mk(1, 6'b000000, INIT_O,        0, 0, "rst0"));
    tbl.push_back(mk(1, 6'b100000, INIT_O,        0, 0, "rst1"));
    tbl.push_back(mk(1, 6'b000010, INIT_O,        0, 0, "rst2"));
    tbl.push_back(mk(0, 6'b100000, INIT_O,        0, 0, "init0"));
    tbl.push_back(mk(0, 6'b000001, INIT_O,        0, 0, "init1"));
    tbl.push_back(mk(0, 6'b000000, 10'b0000000000, 0, 0, "run_idle"));
    tbl.push_back(mk(0, 6'b100000, 10'b0000110001, 0, 0, "br0"));
    tbl.push_back(mk(0, 6'b000000, 10'b0000100000, 1, 0, "br1"));
    tbl.push_back(mk(0, 6'b000000, 10'b0000000000, 1, 0, "br2"));
    tbl.push_back(mk(0, 6'b001000, 10'b1100010000, 1, 0, "load_use"));
    tbl.push_back(mk(0, 6'b000000, 10'b0000000000, 1, 1, "load_use_end"));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 6'b100010, 10'b1111000100, 1, 1 + i, $sformatf("mem_busy%0d", i)));
    tbl.push_back(mk(0, 6'b100000, 10'b0000110001, 1, 5, "mem_busy_redirect"));
    tbl.push_back(mk(0, 6'b000000, 10'b0000100000, 2, 5, "mem_busy_bubble"));
    tbl.push_back(mk(0, 6'b101001, 10'b0000111010, 2, 5, "trap_combo"));
    tbl.push_back(mk(0, 6'b000100, 10'b1000100000, 3, 5, "redirect_if_busy"));
    tbl.push_back(mk(0, 6'b000100, 10'b1000100000, 3, 6, "if_busy"));
    tbl.push_back(mk(0, 6'b000000, 10'b0000000000, 3, 7, "idle2"));
    tbl.push_back(mk(0, 6'b010000, 10'b0000110001, 3, 7, "jump"));
    tbl.push_back(mk(0, 6'b000010, 10'b1011100100, 4, 7, "redirect_mem_busy"));
    tbl.push_back(mk(0, 6'b000000, 10'b0000100000, 4, 8, "redirect_resume"));
    tbl.push_back(mk(0, 6'b000000, 10'b0000000000, 4, 8, "idle3"));

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].in);
      chk({tbl[i].name, "_out"}, 32'(oa), 32'(tbl[i].exp_o));
      chk({tbl[i].name, "_fcnt"}, 32'(fca), 32'(tbl[i].exp_fc));
      chk({tbl[i].name, "_scnt"}, 32'(sca), 32'(tbl[i].exp_sc));
      model_checks(tbl[i].r, tbl[i].in);
      tick();
    end

    // 20 branches drive the 4-bit flush counter into saturation
    for (int i = 0; i < 20; i++) begin
      drive(0, 6'b100000); model_checks(0, 6'b100000); tick();
      drive(0, 6'b000000); model_checks(0, 6'b000000); tick();
    end
    drive(0, 6'b000000);
    chk("flush_cnt_saturated", 32'(fca), 32'd15);
    model_checks(0, 6'b000000);
    tick();

    // Reset arriving while in the redirect bubble
    drive(0, 6'b100000); model_checks(0, 6'b100000); tick();
    drive(1, 6'b000000);
    chk("rst_in_redirect_out", 32'(oa), 32'(INIT_O));
    model_checks(1, 6'b000000);
    tick();
    drive(0, 6'b000000);
    chk("after_rst_out", 32'(oa), 32'(INIT_O));
    chk("after_rst_fcnt", 32'(fca), 32'd0);
    chk("after_rst_scnt", 32'(sca), 32'd0);
    model_checks(0, 6'b000000);
    tick();

    for (int i = 0; i < 3000; i++) begin
      bit r;
      bit [5:0] in;
      r = ($urandom_range(99) == 0);
      for (int b = 0; b < 6; b++) in[b] = ($urandom_range(3) == 0);
      drive(r, in);
      model_checks(r, in);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
